rv32im_mem_arb: RTL and testbench

- Arbitrates the core's single memory port between two requesters: the instruction-fetch path and the execute unit's load/store path.
- Accepts one request at a time, drives the memory port, and routes the response back to the requester that issued it.
- Supports one outstanding transaction, with fixed load/store priority, a fetch anti-starvation guard and a response timeout.
- Sits between the fetch/exu request ports and the external memory interface.

---
 rtl/rv32im_mem_arb.sv | 127 ++++++++++++
 tb/tb_rv32im_mem_arb.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/rv32im_mem_arb.sv
// rv32im_mem_arb: arbitrates one memory port between instruction fetch and load/store
// Ports:
//   clk_i, rst_ni          clock, async active-low reset
//   if_*                   fetch request (req/addr) and response (gnt/rvalid/rdata/err)
//   ls_*                   load/store request (req/we/be/addr/wdata) and response
//   mem_*                  external memory request (req/we/be/addr/wdata) and response (gnt/rvalid/rdata)
//   busy_o                 a transaction is in flight
module rv32im_mem_arb #(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int TIMEOUT       = 255,
    parameter int MAX_LS_STREAK = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_err_o,
    input  logic              ls_req_i,
    input  logic              ls_we_i,
    input  logic [3:0]        ls_be_i,
    input  logic [ADDR_W-1:0] ls_addr_i,
    input  logic [DATA_W-1:0] ls_wdata_i,
    output logic              ls_gnt_o,
    output logic              ls_rvalid_o,
    output logic [DATA_W-1:0] ls_rdata_o,
    output logic              ls_err_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [3:0]        mem_be_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              busy_o
);
    localparam int SW = ($clog2(MAX_LS_STREAK + 1) < 3) ? 3 : $clog2(MAX_LS_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_LS_STREAK);
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t            state, state_nxt;
    logic              owner_ls;
    logic              we_q;
    logic [3:0]        be_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [15:0]       cnt;
    logic [SW-1:0]     streak;
    logic              ls_gnt, if_gnt, done, tmo, fin;

    // a completing response in the same cycle as the timeout takes precedence
    assign tmo = (state != IDLE) && (cnt == TMO_LAST);
    assign fin = done || tmo;

    always_comb begin
        state_nxt = state;
        ls_gnt    = 1'b0;
        if_gnt    = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                // grants are combinational, so they are masked while reset is held
                ls_gnt    = rst_ni && ls_req_i && !(if_req_i && streak == STREAK_MAX);
                if_gnt    = rst_ni && if_req_i && !ls_gnt;
                state_nxt = (ls_gnt || if_gnt) ? REQ : IDLE;
            end
            REQ:     state_nxt = tmo ? IDLE : mem_gnt_i ? WAIT : REQ;
            WAIT: begin
                done      = mem_rvalid_i;
                state_nxt = (mem_rvalid_i || tmo) ? IDLE : WAIT;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= IDLE;
            owner_ls <= 1'b0;
            we_q     <= 1'b0;
            be_q     <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            cnt      <= '0;
            streak   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= (ls_gnt || if_gnt) ? '0 : (state != IDLE) ? cnt + 16'd1 : cnt;
            if (ls_gnt) begin
                owner_ls <= 1'b1;
                we_q     <= ls_we_i;
                be_q     <= ls_be_i;
                addr_q   <= ls_addr_i;
                wdata_q  <= ls_wdata_i;
                streak   <= if_req_i ? ((streak == STREAK_MAX) ? streak : streak + SW'(1)) : '0;
            end else if (if_gnt) begin
                owner_ls <= 1'b0;
                we_q     <= 1'b0;
                be_q     <= 4'hF;
                addr_q   <= if_addr_i & ~ADDR_W'(3);
                wdata_q  <= '0;
                streak   <= '0;
            end
        end
    end

    assign if_gnt_o    = if_gnt;
    assign ls_gnt_o    = ls_gnt;
    assign busy_o      = state != IDLE;
    assign mem_req_o   = (state == REQ) && !tmo;
    assign mem_we_o    = mem_req_o && we_q;
    assign mem_be_o    = mem_req_o ? be_q : '0;
    assign mem_addr_o  = mem_req_o ? addr_q : '0;
    assign mem_wdata_o = mem_req_o ? wdata_q : '0;
    assign if_rvalid_o = fin && !owner_ls;
    assign ls_rvalid_o = fin && owner_ls;
    assign if_err_o    = if_rvalid_o && !done;
    assign ls_err_o    = ls_rvalid_o && !done;
    assign if_rdata_o  = (done && !owner_ls) ? mem_rdata_i : '0;
    assign ls_rdata_o  = (done && owner_ls) ? mem_rdata_i : '0;
endmodule

// File: tb/tb_rv32im_mem_arb.sv
// tb_rv32im_mem_arb: directed cycle-vector and sequence checks for rv32im_mem_arb
module tb_rv32im_mem_arb;
    logic        clk, rst_n;
    logic        if_req, if_gnt, if_rvalid, if_err;
    logic [31:0] if_addr, if_rdata;
    logic        ls_req, ls_we, ls_gnt, ls_rvalid, ls_err;
    logic [3:0]  ls_be, mem_be;
    logic [31:0] ls_addr, ls_wdata, ls_rdata;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid, busy;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [8:0]  flags;
    int          checks = 0;
    int          errors = 0;

    rv32im_mem_arb #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8), .MAX_LS_STREAK(4)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
        .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata), .if_err_o(if_err),
        .ls_req_i(ls_req), .ls_we_i(ls_we), .ls_be_i(ls_be), .ls_addr_i(ls_addr),
        .ls_wdata_i(ls_wdata), .ls_gnt_o(ls_gnt), .ls_rvalid_o(ls_rvalid),
        .ls_rdata_o(ls_rdata), .ls_err_o(ls_err),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_be_o(mem_be), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid),
        .mem_rdata_i(mem_rdata), .busy_o(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign flags = {if_gnt, if_rvalid, if_err, ls_gnt, ls_rvalid, ls_err, mem_req, mem_we, busy};

    typedef struct {
        logic        if_req;
        logic [31:0] if_addr;
        logic        ls_req;
        logic        ls_we;
        logic [3:0]  ls_be;
        logic [31:0] ls_addr;
        logic [31:0] ls_wdata;
        logic        mem_gnt;
        logic        mem_rvalid;
        logic [31:0] mem_rdata;
        logic [8:0]  flags;
        logic [31:0] if_rdata;
        logic [31:0] ls_rdata;
        logic [3:0]  mem_be;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int gseq[8];
        int ng;
        int exp_seq[6];
        // flags order: if_gnt if_rvalid if_err ls_gnt ls_rvalid ls_err mem_req mem_we busy
        tbl[0]  = '{1, 32'h1007, 1, 0, 4'hF, 32'h100, 0, 0, 0, 0, 9'b000100000, 0, 0, 0, 0, 0};
        tbl[1]  = '{1, 32'h1007, 0, 0, 4'hF, 32'h100, 0, 1, 0, 0, 9'b000000101, 0, 0, 4'hF, 32'h100, 0};
        tbl[2]  = '{1, 32'h1007, 0, 0, 0, 0, 0, 0, 1, 32'hAAAA5555, 9'b000010001, 0, 32'hAAAA5555, 0, 0, 0};
        tbl[3]  = '{1, 32'h1007, 0, 0, 0, 0, 0, 0, 0, 0, 9'b100000000, 0, 0, 0, 0, 0};
        tbl[4]  = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 9'b000000101, 0, 0, 4'hF, 32'h1004, 0};
        tbl[5]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h13, 9'b010000001, 32'h13, 0, 0, 0, 0};
        tbl[6]  = '{0, 0, 1, 1, 4'b0011, 32'h20000010, 32'hDEADBEEF, 0, 0, 0, 9'b000100000, 0, 0, 0, 0, 0};
        tbl[7]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9'b000000111, 0, 0, 4'b0011, 32'h20000010, 32'hDEADBEEF};
        tbl[8]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hFFFFFFFF, 9'b000000111, 0, 0, 4'b0011, 32'h20000010, 32'hDEADBEEF};
        tbl[9]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9'b000000111, 0, 0, 4'b0011, 32'h20000010, 32'hDEADBEEF};
        tbl[10] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 9'b000000111, 0, 0, 4'b0011, 32'h20000010, 32'hDEADBEEF};
        tbl[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9'b000000001, 0, 0, 0, 0, 0};
        tbl[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h12345678, 9'b000010001, 0, 32'h12345678, 0, 0, 0};
        tbl[13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9'b000000000, 0, 0, 0, 0, 0};
        exp_seq = '{1, 1, 1, 1, 0, 1};

        // reset with both requests high
        rst_n = 1'b0;
        if_req = 1'b1; if_addr = 32'h1007;
        ls_req = 1'b1; ls_we = 1'b0; ls_be = 4'hF; ls_addr = 32'h100; ls_wdata = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        repeat (2) begin
            @(negedge clk);
            chk("reset flags", 32'(flags), 0);
            chk("reset data", 32'(|{if_rdata, ls_rdata, mem_be, mem_addr, mem_wdata}), 0);
        end
        tick();
        rst_n = 1'b1;

        // load, fetch, then a delayed-grant store
        for (int i = 0; i < 14; i++) begin
            if_req = tbl[i].if_req; if_addr = tbl[i].if_addr;
            ls_req = tbl[i].ls_req; ls_we = tbl[i].ls_we; ls_be = tbl[i].ls_be;
            ls_addr = tbl[i].ls_addr; ls_wdata = tbl[i].ls_wdata;
            mem_gnt = tbl[i].mem_gnt; mem_rvalid = tbl[i].mem_rvalid; mem_rdata = tbl[i].mem_rdata;
            @(negedge clk);
            chk($sformatf("row%0d flags", i), 32'(flags), 32'(tbl[i].flags));
            chk($sformatf("row%0d if_rdata", i), if_rdata, tbl[i].if_rdata);
            chk($sformatf("row%0d ls_rdata", i), ls_rdata, tbl[i].ls_rdata);
            chk($sformatf("row%0d mem_be", i), 32'(mem_be), 32'(tbl[i].mem_be));
            chk($sformatf("row%0d mem_addr", i), mem_addr, tbl[i].mem_addr);
            chk($sformatf("row%0d mem_wdata", i), mem_wdata, tbl[i].mem_wdata);
            tick();
        end

        // both requesters held: fetch gets in after four load/store grants
        for (int i = 0; i < 8; i++) gseq[i] = 2;
        ng = 0;
        if_req = 1'b1; if_addr = 32'h600;
        ls_req = 1'b1; ls_we = 1'b0; ls_be = 4'hF; ls_addr = 32'h500;
        mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h77;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("gnt exclusive", 32'(ls_gnt & if_gnt), 0);
            if ((ls_gnt || if_gnt) && ng < 8) begin
                gseq[ng] = ls_gnt ? 1 : 0;
                ng++;
            end
            tick();
        end
        chk("grant count", 32'(ng >= 6), 1);
        for (int i = 0; i < 6; i++) chk($sformatf("grant%0d is_ls", i), gseq[i], exp_seq[i]);
        if_req = 1'b0; ls_req = 1'b0;
        repeat (2) tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        @(negedge clk);
        chk("drain busy", 32'(busy), 0);
        tick();

        // timeout with the memory never granting
        ls_req = 1'b1; ls_we = 1'b0; ls_be = 4'hF; ls_addr = 32'h700;
        mem_rdata = 32'hCAFEF00D;
        @(negedge clk);
        chk("tmo grant", 32'(ls_gnt), 1);
        for (int k = 1; k <= 10; k++) begin
            tick();
            ls_req = 1'b0;
            mem_rvalid = (k == 10);
            @(negedge clk);
            if (k <= 8) begin
                chk($sformatf("tmo k%0d ls_rvalid", k), 32'(ls_rvalid), 32'(k == 8));
                chk($sformatf("tmo k%0d ls_err", k), 32'(ls_err), 32'(k == 8));
                chk($sformatf("tmo k%0d mem_req", k), 32'(mem_req), 32'(k != 8));
            end
            if (k == 8) begin
                chk("tmo rdata", ls_rdata, 0);
                chk("tmo busy", 32'(busy), 1);
            end
            if (k == 9) chk("tmo busy drop", 32'(busy), 0);
            if (k == 10) begin
                chk("late rvalid flags", 32'(flags), 0);
                chk("late rvalid rdata", ls_rdata, 0);
            end
        end
        tick();
        mem_rvalid = 1'b0;

        // reset while waiting for a response
        if_req = 1'b1; if_addr = 32'h3000;
        @(negedge clk);
        chk("rst6 if_gnt", 32'(if_gnt), 1);
        tick();
        if_req = 1'b0; mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        @(negedge clk);
        chk("rst6 wait busy", 32'(busy), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst6 busy now", 32'(busy), 0);
        chk("rst6 flags now", 32'(flags), 0);
        tick();
        rst_n = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = 32'hBAD;
        @(negedge clk);
        chk("rst6 stray rvalid", 32'(flags), 0);
        chk("rst6 stray rdata", if_rdata, 0);
        tick();
        mem_rvalid = 1'b0;
        if_req = 1'b1; if_addr = 32'h4002;
        @(negedge clk);
        chk("rst6 fetch gnt", 32'(flags), 32'(9'b100000000));
        tick();
        if_req = 1'b0; mem_gnt = 1'b1;
        @(negedge clk);
        chk("rst6 fetch req", 32'(flags), 32'(9'b000000101));
        chk("rst6 fetch addr", mem_addr, 32'h4000);
        tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h00500093;
        @(negedge clk);
        chk("rst6 fetch resp", 32'(flags), 32'(9'b010000001));
        chk("rst6 fetch rdata", if_rdata, 32'h00500093);
        tick();
        mem_rvalid = 1'b0;
        @(negedge clk);
        chk("rst6 idle", 32'(flags), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
